// File: rtl/axis_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_spi_slave
// Purpose  : Oversampled SPI responder; MOSI words out on m_axis, MISO from s_axis
// Revision : 1.0 - initial release
// ============================================================================
module axis_spi_slave #(
    parameter int                    SPI_MODE    = 1,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD   = '0
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  spi_clk_i,
    input  logic                  spi_cs_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    output logic                  m_axis_tlast_o,
    input  logic                  m_axis_tready_i,
    output logic                  overflow_o,
    output logic                  underrun_o,
    output logic                  frame_err_o
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam int   CW   = $clog2(DATA_WIDTH);
    localparam int   MSB  = DATA_WIDTH - 1;

    typedef enum logic [1:0] {RESYNC, IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [SYNC_STAGES:0]   settle_q;
    logic                   miso_q, oe_q, src_valid_q, done_q;
    logic [DATA_WIDTH-1:0]  tx_sh_q, rx_sh_q, hold_q, push_data_q, m_data_q;
    logic [CW-1:0]          bit_cnt_q;
    logic                   hold_v_q, push_q, push_last_q, m_valid_q, m_last_q;
    logic                   ovf_q, unr_q, ferr_q;

    logic sclk_s, cs_s, mosi_s, sclk_tgl, lead_e, trail_e, sample_e, shift_e;
    logic cs_fall, cs_rise, active, cnt_zero, last_bit, word_start, commit, shift_bit;

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_tgl = sclk_s ^ sclk_prev_q;
    assign lead_e   = sclk_tgl && (sclk_prev_q == CPOL);
    assign trail_e  = sclk_tgl && (sclk_s == CPOL);
    assign sample_e = CPHA ? trail_e : lead_e;
    assign shift_e  = CPHA ? lead_e : trail_e;
    assign cs_fall  = cs_prev_q && !cs_s;
    assign cs_rise  = !cs_prev_q && cs_s;

    // A CS rise aborts the frame, so any SCLK edge seen in the same cycle is dropped.
    assign active     = (state_q == ACTIVE) && !cs_rise;
    assign cnt_zero   = (bit_cnt_q == '0);
    assign last_bit   = (bit_cnt_q == CW'(DATA_WIDTH - 1));
    assign word_start = (active && shift_e && cnt_zero) ||
                        (!CPHA && (state_q == IDLE) && cs_fall);
    assign commit     = active && sample_e && cnt_zero;
    assign shift_bit  = active && shift_e && !cnt_zero;

    assign s_axis_tready_o = commit && src_valid_q;
    assign spi_miso_o      = miso_q;
    assign spi_miso_oe_o   = oe_q;
    assign m_axis_tdata_o  = m_data_q;
    assign m_axis_tvalid_o = m_valid_q;
    assign m_axis_tlast_o  = m_last_q;
    assign overflow_o      = ovf_q;
    assign underrun_o      = unr_q;
    assign frame_err_o     = ferr_q;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
            settle_q    <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) state_q <= RESYNC;
        else          state_q <= state_d;
    end

    // The synchronizer resets to CS=1, so RESYNC waits until the chain reflects the real pin.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RESYNC:  if (settle_q[SYNC_STAGES] && cs_s) state_d = IDLE;
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = RESYNC;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            miso_q <= 1'b0;  oe_q <= 1'b0;  src_valid_q <= 1'b0;  done_q <= 1'b0;
            tx_sh_q <= '0;   rx_sh_q <= '0; hold_q <= '0;         push_data_q <= '0;
            m_data_q <= '0;  bit_cnt_q <= '0;
            hold_v_q <= 1'b0; push_q <= 1'b0; push_last_q <= 1'b0;
            m_valid_q <= 1'b0; m_last_q <= 1'b0;
            ovf_q <= 1'b0;   unr_q <= 1'b0; ferr_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            unr_q  <= 1'b0;
            ferr_q <= 1'b0;
            oe_q   <= (state_d == ACTIVE);

            // Peek at the next source word; the handshake waits for the first sample edge.
            if (word_start) begin
                src_valid_q <= s_axis_tvalid_i;
                miso_q      <= s_axis_tvalid_i ? s_axis_tdata_i[MSB] : FILL_WORD[MSB];
                unr_q       <= !s_axis_tvalid_i;
            end
            if (commit)
                tx_sh_q <= (src_valid_q ? s_axis_tdata_i : FILL_WORD) << 1;
            if (shift_bit) begin
                miso_q  <= tx_sh_q[MSB];
                tx_sh_q <= {tx_sh_q[MSB-1:0], 1'b0};
            end
            if (active && sample_e) begin
                rx_sh_q   <= {rx_sh_q[MSB-1:0], mosi_s};
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + CW'(1);
                done_q    <= last_bit;
            end

            // One-word hold lets the frame's final word carry tlast once CS rises.
            if (done_q) begin
                if (hold_v_q) begin
                    push_q      <= 1'b1;
                    push_data_q <= hold_q;
                    push_last_q <= 1'b0;
                end
                hold_q   <= rx_sh_q;
                hold_v_q <= 1'b1;
            end
            if ((state_q == ACTIVE) && cs_rise) begin
                if (hold_v_q) begin
                    push_q      <= 1'b1;
                    push_data_q <= hold_q;
                    push_last_q <= 1'b1;
                end
                hold_v_q    <= 1'b0;
                src_valid_q <= 1'b0;
                bit_cnt_q   <= '0;
                if (!cnt_zero) begin
                    ferr_q  <= 1'b1;
                    rx_sh_q <= '0;
                end
            end

            if (push_q) begin
                if (m_valid_q && !m_axis_tready_i) begin
                    ovf_q <= 1'b1;
                end else begin
                    m_valid_q <= 1'b1;
                    m_data_q  <= push_data_q;
                    m_last_q  <= push_last_q;
                end
            end else if (m_valid_q && m_axis_tready_i) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axis_spi_slave
// Purpose  : Directed bench driving one responder instance per SPI mode
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_spi_slave;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        arstn;
    logic [3:0]  cs_p, sclk_p, mosi_p, m_ready, s_valid;
    logic [7:0]  s_data;
    wire  [3:0]  miso_p, oe_p, s_ready, m_valid, m_last, ovf, unr, ferr;
    wire  [31:0] m_data_flat;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        axis_spi_slave #(
            .SPI_MODE(g), .DATA_WIDTH(8), .SYNC_STAGES(2), .FILL_WORD(8'hFF)
        ) u_dut (
            .clk_i(clk), .arstn_i(arstn),
            .spi_clk_i(sclk_p[g]), .spi_cs_i(cs_p[g]), .spi_mosi_i(mosi_p[g]),
            .spi_miso_o(miso_p[g]), .spi_miso_oe_o(oe_p[g]),
            .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid[g]), .s_axis_tready_o(s_ready[g]),
            .m_axis_tdata_o(m_data_flat[g*8 +: 8]), .m_axis_tvalid_o(m_valid[g]),
            .m_axis_tlast_o(m_last[g]), .m_axis_tready_i(m_ready[g]),
            .overflow_o(ovf[g]), .underrun_o(unr[g]), .frame_err_o(ferr[g])
        );
    end

    int         cur = 0;
    int         tx_n = 0, tx_base = 0, tx_cnt = 0, idx;
    logic [7:0] tx_w [4];
    logic [8:0] beats [$];
    int         unr_cnt = 0, ovf_cnt = 0, ferr_cnt = 0, rdy_cnt = 0;
    int         checks = 0, passes = 0, fails = 0;
    logic [7:0] m_data_cur;

    assign m_data_cur = m_data_flat[cur*8 +: 8];

    // Source model: presents tx_w[0..tx_n-1] in order to the selected instance.
    always_comb begin
        idx     = tx_cnt - tx_base;
        s_valid = '0;
        s_data  = 8'h00;
        if (idx >= 0 && idx < tx_n) begin
            s_valid[cur] = 1'b1;
            s_data       = tx_w[idx];
        end
    end

    always @(posedge clk)
        if (s_valid[cur] && s_ready[cur]) tx_cnt <= tx_cnt + 1;

    always @(negedge clk) begin
        if (m_valid[cur] && m_ready[cur]) beats.push_back({m_last[cur], m_data_cur});
        if (unr[cur])     unr_cnt++;
        if (ovf[cur])     ovf_cnt++;
        if (ferr[cur])    ferr_cnt++;
        if (s_ready[cur]) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_tx(input int n, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        tx_w[0] = a; tx_w[1] = b; tx_w[2] = c; tx_w[3] = 8'h00;
        tx_base = tx_cnt;
        tx_n    = n;
    endtask

    task automatic spi_word(input logic [7:0] w, input int nbits, output logic [7:0] r);
        logic cpol, cpha;
        logic [7:0] acc;
        cpol = (cur >= 2);
        cpha = (cur == 1) || (cur == 3);
        acc  = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi_p[cur] = w[7-i];
                tick(H);
                acc = {acc[6:0], miso_p[cur]};
                sclk_p[cur] = ~cpol;
                tick(H);
                sclk_p[cur] = cpol;
            end else begin
                sclk_p[cur] = ~cpol;
                mosi_p[cur] = w[7-i];
                tick(H);
                acc = {acc[6:0], miso_p[cur]};
                sclk_p[cur] = cpol;
                tick(H);
            end
        end
        r = acc;
    endtask

    // Words and results are left-aligned: word k sits in bits [23-8k -: 8].
    task automatic frame(input int n, input logic [23:0] words, output logic [23:0] got);
        logic [7:0] r;
        got = 24'h0;
        cs_p[cur] = 1'b0;
        tick(H);
        for (int k = 0; k < n; k++) begin
            spi_word(words[23-8*k -: 8], 8, r);
            got[23-8*k -: 8] = r;
        end
        tick(H);
        cs_p[cur] = 1'b1;
        tick(4*H);
    endtask

    logic [23:0] got;
    logic [7:0]  r8;
    int          b0, u0, o0, f0, r0;

    initial begin
        arstn   = 1'b0;
        cs_p    = 4'b1111;
        sclk_p  = 4'b1100;
        mosi_p  = 4'b0000;
        m_ready = 4'b1111;
        set_tx(0, 8'h00, 8'h00, 8'h00);
        tick(3);
        chk("rst_miso",   32'(miso_p), 32'h0);
        chk("rst_oe",     32'(oe_p), 32'h0);
        chk("rst_tready", 32'(s_ready), 32'h0);
        chk("rst_tvalid", 32'(m_valid), 32'h0);
        chk("rst_tlast",  32'(m_last), 32'h0);
        chk("rst_tdata",  m_data_flat, 32'h0);
        chk("rst_pulses", 32'({ovf, unr, ferr}), 32'h0);
        arstn = 1'b1;
        tick(5);

        // Mode 0 single word
        cur = 0;
        set_tx(1, 8'h3C, 8'h00, 8'h00);
        b0 = beats.size(); r0 = rdy_cnt;
        frame(1, 24'hA50000, got);
        chk("m0_miso",   32'(got[23:16]), 32'h3C);
        chk("m0_tready", 32'(rdy_cnt - r0), 32'd1);
        chk("m0_nbeats", 32'(beats.size() - b0), 32'd1);
        chk("m0_beat",   32'(beats[b0]), 32'h1A5);

        // Modes 1..3, three-word frame
        for (int m = 1; m < 4; m++) begin
            cur = m;
            set_tx(3, 8'h11, 8'h22, 8'h33);
            b0 = beats.size();
            frame(3, 24'h010203, got);
            chk("m123_miso",   32'(got), 32'h112233);
            chk("m123_nbeats", 32'(beats.size() - b0), 32'd3);
            chk("m123_beat0",  32'(beats[b0]),   32'h001);
            chk("m123_beat1",  32'(beats[b0+1]), 32'h002);
            chk("m123_beat2",  32'(beats[b0+2]), 32'h103);
        end

        // Underrun: empty source, two words
        cur = 1;
        set_tx(0, 8'h00, 8'h00, 8'h00);
        b0 = beats.size(); u0 = unr_cnt; r0 = rdy_cnt;
        frame(2, 24'h123400, got);
        chk("unr_miso",   32'(got[23:8]), 32'hFFFF);
        chk("unr_pulses", 32'(unr_cnt - u0), 32'd2);
        chk("unr_tready", 32'(rdy_cnt - r0), 32'd0);
        chk("unr_nbeats", 32'(beats.size() - b0), 32'd2);
        chk("unr_beat1",  32'(beats[b0+1]), 32'h134);

        // Overflow: sink stalled for a three-word frame
        m_ready[1] = 1'b0;
        set_tx(3, 8'h11, 8'h22, 8'h33);
        b0 = beats.size(); o0 = ovf_cnt;
        frame(3, 24'h010203, got);
        chk("ovf_pulses", 32'(ovf_cnt - o0), 32'd2);
        chk("ovf_tvalid", 32'(m_valid[1]), 32'd1);
        chk("ovf_tdata",  32'(m_data_cur), 32'h01);
        chk("ovf_tlast",  32'(m_last[1]), 32'd0);
        m_ready[1] = 1'b1;
        tick(4);
        chk("ovf_nbeats", 32'(beats.size() - b0), 32'd1);
        chk("ovf_beat",   32'(beats[b0]), 32'h001);
        chk("ovf_drain",  32'(m_valid[1]), 32'd0);

        // Frame error: CS released after 5 bits, then a clean frame
        set_tx(1, 8'h99, 8'h00, 8'h00);
        b0 = beats.size(); f0 = ferr_cnt;
        cs_p[1] = 1'b0;
        tick(H);
        spi_word(8'hC3, 5, r8);
        tick(H);
        cs_p[1] = 1'b1;
        tick(4*H);
        chk("ferr_pulse",  32'(ferr_cnt - f0), 32'd1);
        chk("ferr_nbeats", 32'(beats.size() - b0), 32'd0);
        set_tx(1, 8'hA6, 8'h00, 8'h00);
        frame(1, 24'h5A0000, got);
        chk("ferr_next_miso",   32'(got[23:16]), 32'hA6);
        chk("ferr_next_nbeats", 32'(beats.size() - b0), 32'd1);
        chk("ferr_next_beat",   32'(beats[b0]), 32'h15A);

        // Reset while CS stays low: rest of the frame must be ignored
        set_tx(0, 8'h00, 8'h00, 8'h00);
        b0 = beats.size();
        cs_p[1] = 1'b0;
        tick(H);
        spi_word(8'h11, 8, r8);
        arstn = 1'b0;
        tick(3);
        arstn = 1'b1;
        tick(H);
        spi_word(8'h22, 8, r8);
        spi_word(8'h33, 8, r8);
        tick(H);
        chk("rsync_oe", 32'(oe_p[1]), 32'd0);
        cs_p[1] = 1'b1;
        tick(4*H);
        chk("rsync_nbeats", 32'(beats.size() - b0), 32'd0);
        frame(1, 24'h770000, got);
        chk("rsync_next_nbeats", 32'(beats.size() - b0), 32'd1);
        chk("rsync_next_beat",   32'(beats[b0]), 32'h177);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
